uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 39 +++
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types, address map and FSM encoding for the UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned DATA_W     = 32;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_bus;
  typedef logic [DATA_W-1:0]     data_bus;

  // Address window of the receiver, next to the tim/uart windows.
  localparam mem_addr_bus uart_rx_addr_start = 32'h0000_0300;
  localparam mem_addr_bus uart_rx_addr_end   = 32'h0000_030F;

  // Register byte offsets inside the window.
  localparam logic [3:0] uart_rx_rxdata_off = 4'h0;
  localparam logic [3:0] uart_rx_status_off = 4'h4;
  localparam logic [3:0] uart_rx_ctrl_off   = 4'h8;
  localparam logic [3:0] uart_rx_baud_off   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  function automatic logic addr_hit(input mem_addr_bus a);
    return (a >= uart_rx_addr_start) && (a <= uart_rx_addr_end);
  endfunction

  function automatic logic [3:0] reg_off(input mem_addr_bus a);
    mem_addr_bus d;
    d = a - uart_rx_addr_start;
    return d[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with occupancy count; power-of-two depth, pointers wrap naturally.
// Latency: pushed data visible at head the cycle after the push.
// Backpressure: push while full (without a pop) is ignored; pop while empty is ignored.
// Ports: push_i/push_dat_i write, pop_i advances head, head_dat_o, full_o, empty_o, count_o.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push+pop while full is legal.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: 16x oversampled 8N1 framing into a small byte FIFO.
// Latency: register reads return one cycle after the read strobe; a byte is queued at its mid-stop sample.
// Backpressure: none on the line; a byte arriving with the FIFO full is dropped and flagged as overrun.
// Ports: clk/rst_n, bus read/write address+strobes, write data in, registered read data out, rx line, level irq.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = 16'd26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  mem_addr_bus uart_rx_r_addr_i,
  input  mem_addr_bus uart_rx_w_addr_i,
  input  data_bus     uart_rx_data_i,
  input  logic        uart_rx_r_enable_i,
  input  logic        uart_rx_w_enable_i,
  output data_bus     uart_rx_data_o,
  input  logic        rx,
  output logic        uart_rx_irq_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_e   state_q, state_d;
  logic        hold_q, hold_d;          // stop bit was low: wait for line to return high
  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  data_bus     rdata_q, rdata_d;

  logic             tick, push, pop, set_fe, clr_sticky;
  logic             wr_hit, rd_hit;
  logic [3:0]       wr_off, rd_off;
  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       count8;
  logic [7:0]       status;
  logic             unused_ok;

  assign unused_ok = ^uart_rx_data_i[31:16];

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (shift_q),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign count8 = 8'(fifo_count);
  assign status = {count8[3:0], frame_err_q, overrun_q, fifo_full, ~fifo_empty};
  assign tick   = (baud_cnt_q == baud_q);

  assign uart_rx_data_o = rdata_q;
  assign uart_rx_irq_o  = ctrl_q[1] & (~fifo_empty | overrun_q | frame_err_q);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    baud_cnt_d  = tick ? 16'd0 : baud_cnt_q + 16'd1;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    baud_d      = baud_q;
    rdata_d     = rdata_q;
    push        = 1'b0;
    pop         = 1'b0;
    set_fe      = 1'b0;
    clr_sticky  = 1'b0;
    wr_hit      = uart_rx_w_enable_i && addr_hit(uart_rx_w_addr_i);
    rd_hit      = uart_rx_r_enable_i && addr_hit(uart_rx_r_addr_i);
    wr_off      = reg_off(uart_rx_w_addr_i);
    rd_off      = reg_off(uart_rx_r_addr_i);

    // Receive FSM; the start bit is qualified at its middle (tick 7), every
    // later sample lands 16 ticks on, i.e. in the middle of each bit.
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = ST_START;
          tick_cnt_d = 4'd0;
          baud_cnt_d = 16'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            shift_d    = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (hold_q) begin
          if (rx_sync_q) begin
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            if (rx_sync_q) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              set_fe  = 1'b1;
              hold_d  = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the receiver abandons any frame in flight; FIFO is kept.
    if (!ctrl_q[0]) begin
      state_d = ST_IDLE;
      hold_d  = 1'b0;
      push    = 1'b0;
      set_fe  = 1'b0;
    end

    if (wr_hit) begin
      case (wr_off)
        uart_rx_status_off: clr_sticky = 1'b1;
        uart_rx_ctrl_off:   ctrl_d     = uart_rx_data_i[1:0];
        uart_rx_baud_off: begin
          baud_d     = uart_rx_data_i[15:0];
          baud_cnt_d = 16'd0;
        end
        default: ;
      endcase
    end

    if (uart_rx_r_enable_i) begin
      rdata_d = '0;
      if (rd_hit) begin
        case (rd_off)
          uart_rx_rxdata_off: begin
            if (!fifo_empty) begin
              rdata_d = {24'd0, fifo_head};
              pop     = 1'b1;
            end
          end
          uart_rx_status_off: rdata_d = {24'd0, status};
          uart_rx_ctrl_off:   rdata_d = {30'd0, ctrl_q};
          uart_rx_baud_off:   rdata_d = {16'd0, baud_q};
          default:            rdata_d = '0;
        endcase
      end
    end

    // New error events win over a simultaneous clear.
    overrun_d   = (overrun_q & ~clr_sticky) | (push & fifo_full & ~pop);
    frame_err_d = (frame_err_q & ~clr_sticky) | set_fe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      baud_cnt_q  <= 16'd0;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      ctrl_q      <= 2'd0;
      baud_q      <= BAUD_RESET;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      baud_cnt_q  <= baud_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      baud_q      <= baud_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam mem_addr_bus A_RXDATA = uart_rx_addr_start + 32'h0;
  localparam mem_addr_bus A_STATUS = uart_rx_addr_start + 32'h4;
  localparam mem_addr_bus A_CTRL   = uart_rx_addr_start + 32'h8;
  localparam mem_addr_bus A_BAUD   = uart_rx_addr_start + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  mem_addr_bus r_addr = '0;
  mem_addr_bus w_addr = '0;
  data_bus     w_data = '0;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  data_bus     r_data;
  logic        rx = 1'b1;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model: what the receiver should be holding, as a plain queue.
  byte unsigned exp_q[$];
  bit           exp_ov = 1'b0;
  bit           exp_fe = 1'b0;
  int           cpb = 16 * 27;
  logic [31:0]  rd;

  uart_rx #(.FIFO_DEPTH(DEPTH), .BAUD_RESET(16'd26)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .uart_rx_r_addr_i   (r_addr),
    .uart_rx_w_addr_i   (w_addr),
    .uart_rx_data_i     (w_data),
    .uart_rx_r_enable_i (r_en),
    .uart_rx_w_enable_i (w_en),
    .uart_rx_data_o     (r_data),
    .rx                 (rx),
    .uart_rx_irq_o      (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status();
    int n;
    n = exp_q.size();
    return {24'd0, 4'(n), exp_fe, exp_ov, (n == DEPTH), (n != 0)};
  endfunction

  function automatic logic [31:0] model_read();
    if (exp_q.size() == 0) return 32'd0;
    return {24'd0, exp_q.pop_front()};
  endfunction

  task automatic bus_write(input mem_addr_bus a, input logic [31:0] d);
    @(negedge clk);
    w_addr = a; w_data = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
    if (a == A_STATUS) begin exp_ov = 1'b0; exp_fe = 1'b0; end
  endtask

  task automatic bus_read(input mem_addr_bus a, output logic [31:0] d);
    @(negedge clk);
    r_addr = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = r_data;
  endtask

  task automatic set_baud(input int b);
    bus_write(A_BAUD, 32'(b));
    cpb = 16 * (b + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame plus one idle bit; the model is updated from the frame rules.
  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0; idle(cpb);
    for (int i = 0; i < 8; i++) begin rx = b[i]; idle(cpb); end
    rx = stop; idle(cpb);
    rx = 1'b1; idle(cpb);
    if (!stop) exp_fe = 1'b1;
    else if (exp_q.size() >= DEPTH) exp_ov = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(3);
    exp_q.delete(); exp_ov = 1'b0; exp_fe = 1'b0; cpb = 16 * 27;
    rst_n = 1'b1; idle(2);
  endtask

  task automatic test_reset();
    rx = 1'b0;
    rst_n = 1'b0; idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (r_data !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", r_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status got %h want 0", rd); end
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", rd); end
    bus_read(A_BAUD, rd);
    checks++; if (rd !== 32'd26) begin errors++; $display("FAIL reset_baud got %h want 1a", rd); end
    bus_read(uart_rx_addr_start + 32'h2, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_off got %h want 0", rd); end
    bus_read(uart_rx_addr_end + 32'h4, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL out_of_range got %h want 0", rd); end
    // Line held low across reset release and enable: no frame may start.
    set_baud(1);
    bus_write(A_CTRL, 32'd1);
    idle(400);
    rx = 1'b1; idle(40);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL low_line_reset got %h want 0", rd); end
  endtask

  task automatic test_basic();
    send_byte(8'hA5, 1'b1);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL basic_status got %h want 11", rd); end
    void'(model_read());
    bus_read(A_RXDATA, rd);
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL basic_data got %h want a5", rd); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL basic_status_after got %h want 0", rd); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h47) begin errors++; $display("FAIL ovf_status got %h want 47", rd); end
    for (int i = 1; i <= 5; i++) begin
      logic [31:0] e;
      e = model_read();
      bus_read(A_RXDATA, rd);
      checks++; if (rd !== e) begin errors++; $display("FAIL ovf_read%0d got %h want %h", i, rd, e); end
    end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h04) begin errors++; $display("FAIL ovf_sticky got %h want 04", rd); end
    bus_write(A_STATUS, 32'd0);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL ovf_clear got %h want 0", rd); end
  endtask

  task automatic test_frame_error();
    send_byte(8'h3C, 1'b0);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL fe_status got %h want 08", rd); end
    bus_write(A_STATUS, 32'd0);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL fe_clear got %h want 0", rd); end
  endtask

  task automatic test_glitch();
    rx = 1'b0; idle(8);
    rx = 1'b1; idle(400);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL glitch_status got %h want 0", rd); end
  endtask

  task automatic test_irq();
    bus_write(A_CTRL, 32'd3);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
    send_byte(8'h5A, 1'b1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq); end
    void'(model_read());
    @(negedge clk);
    r_addr = A_RXDATA; r_en = 1'b1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_during_read got %b want 1", irq); end
    @(negedge clk);
    r_en = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b want 0", irq); end
    checks++; if (r_data !== 32'h5A) begin errors++; $display("FAIL irq_data got %h want 5a", r_data); end
    bus_write(A_CTRL, 32'd1);
  endtask

  task automatic test_disable_midframe();
    send_byte(8'h33, 1'b1);
    rx = 1'b0; idle(cpb);
    rx = 1'b1; idle(cpb);
    rx = 1'b0; idle(cpb / 2);
    bus_write(A_CTRL, 32'd0);
    idle(cpb);
    rx = 1'b1; idle(cpb * 10);
    bus_write(A_CTRL, 32'd1);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL dis_status got %h want 11", rd); end
    void'(model_read());
    bus_read(A_RXDATA, rd);
    checks++; if (rd !== 32'h33) begin errors++; $display("FAIL dis_keep got %h want 33", rd); end
    send_byte(8'h96, 1'b1);
    void'(model_read());
    bus_read(A_RXDATA, rd);
    checks++; if (rd !== 32'h96) begin errors++; $display("FAIL dis_recover got %h want 96", rd); end
  endtask

  task automatic test_reset_midframe();
    rx = 1'b0; idle(cpb);
    rx = 1'b1; idle(cpb);
    rx = 1'b0; idle(cpb);
    rx = 1'b1; idle(cpb / 2);
    do_reset();
    set_baud(1);
    bus_write(A_CTRL, 32'd1);
    idle(20);
    send_byte(8'h7E, 1'b1);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL rstmid_status got %h want 11", rd); end
    void'(model_read());
    bus_read(A_RXDATA, rd);
    checks++; if (rd !== 32'h7E) begin errors++; $display("FAIL rstmid_data got %h want 7e", rd); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL rstmid_empty got %h want 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    set_baud($urandom_range(0, 3));
    for (int i = 0; i < 14; i++) begin
      logic [7:0] b;
      bit stop;
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_byte(b, stop);
      if ($urandom_range(0, 2) == 0) begin
        e = model_read();
        bus_read(A_RXDATA, rd);
        checks++; if (rd !== e) begin errors++; $display("FAIL rand_read%0d got %h want %h", i, rd, e); end
      end
      if (i % 4 == 3) begin
        e = exp_status();
        bus_read(A_STATUS, rd);
        checks++; if (rd !== e) begin errors++; $display("FAIL rand_status%0d got %h want %h", i, rd, e); end
        bus_write(A_STATUS, 32'd0);
      end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      e = model_read();
      bus_read(A_RXDATA, rd);
      checks++; if (rd !== e) begin errors++; $display("FAIL rand_drain%0d got %h want %h", i, rd, e); end
    end
    e = exp_status();
    bus_read(A_STATUS, rd);
    checks++; if (rd !== e) begin errors++; $display("FAIL rand_final got %h want %h", rd, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_frame_error();
    test_glitch();
    test_irq();
    test_disable_midframe();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
